// File: rtl/ss_rr_arbiter_if.sv
// ss_rr_arbiter_if: bundle of the NUM_IN streaming inputs, the merged stream
// output and the grant status of the round-robin packet arbiter.
//   in_valid/in_ready/in_last : per-input handshake and end-of-packet
//   in_data/in_keep/in_user   : packed per-input payload, input i at slice i
//   out_*                     : merged stream output, registered
//   grant_idx/busy            : input owning the output / packet grant held
// slave modport faces the arbiter, master modport faces the traffic source.
interface ss_rr_arbiter_if #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_IN);

  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN*KEEP_W-1:0] in_keep;
  logic [NUM_IN-1:0]        in_last;
  logic [NUM_IN*USER_W-1:0] in_user;

  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [KEEP_W-1:0]        out_keep;
  logic                     out_last;
  logic [USER_W-1:0]        out_user;

  logic [IDX_W-1:0]         grant_idx;
  logic                     busy;

  modport slave (
    input  in_valid, in_data, in_keep, in_last, in_user, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, out_user,
    output grant_idx, busy
  );

  modport master (
    output in_valid, in_data, in_keep, in_last, in_user, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, out_user,
    input  grant_idx, busy
  );
endinterface

// File: rtl/ss_rr_arbiter.sv
// ss_rr_arbiter: packet-level round-robin merge of NUM_IN streams into one.
// An input is chosen in IDLE (search starts after the last winner) and keeps
// the output until its in_last beat is accepted. Accepted beats appear on the
// registered out_* one cycle later; the output register holds under stall.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ss_rr_arbiter_if.slave (inputs, merged output, grant status)

// Per-input ready: only the owning lane may take a beat, and only when the
// output register is free or being drained this cycle.
module ss_rr_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             locked_i,
  input  logic [IDX_W-1:0] grant_i,
  input  logic             can_take_i,
  output logic             ready_o
);
  assign ready_o = locked_i && (grant_i == IDX_W'(LANE)) && can_take_i;
endmodule

module ss_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
) (
  input logic          clk,
  input logic          rst,
  ss_rr_arbiter_if.slave bus
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_IN);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] grant_q, last_q, pick_d, idx;
  logic             any_req, can_take, acc;
  logic [NUM_IN-1:0] rdy;

  logic              ovld_q, olast_q;
  logic [DATA_W-1:0] odata_q;
  logic [KEEP_W-1:0] okeep_q;
  logic [USER_W-1:0] ouser_q;

  // Packed views share the bit layout of the flat buses.
  logic [NUM_IN-1:0][DATA_W-1:0] d_arr;
  logic [NUM_IN-1:0][KEEP_W-1:0] k_arr;
  logic [NUM_IN-1:0][USER_W-1:0] u_arr;

  assign d_arr = bus.in_data;
  assign k_arr = bus.in_keep;
  assign u_arr = bus.in_user;

  assign can_take = !ovld_q || bus.out_ready;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    ss_rr_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .locked_i   (state_q == LOCKED),
      .grant_i    (grant_q),
      .can_take_i (can_take),
      .ready_o    (rdy[i])
    );
  end

  assign bus.in_ready = rdy;
  assign acc          = |(bus.in_valid & rdy);

  // Round-robin search: first requester at last_q+1, last_q+2, ... wrapping,
  // so the previous winner has lowest priority.
  always_comb begin
    pick_d  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = IDX_W'((int'(last_q) + k) % NUM_IN);
      if (!any_req && bus.in_valid[idx]) begin
        any_req = 1'b1;
        pick_d  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_IN - 1);
      ovld_q  <= 1'b0;
      olast_q <= 1'b0;
      odata_q <= '0;
      okeep_q <= '0;
      ouser_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q <= pick_d;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          // Grant is released only by an accepted last beat.
          if (acc && bus.in_last[grant_q]) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Output register: load on accept, else drain on handshake, else hold.
      if (acc) begin
        ovld_q  <= 1'b1;
        odata_q <= d_arr[grant_q];
        okeep_q <= k_arr[grant_q];
        olast_q <= bus.in_last[grant_q];
        ouser_q <= u_arr[grant_q];
      end else if (bus.out_ready) begin
        ovld_q  <= 1'b0;
      end
    end
  end

  assign bus.out_valid = ovld_q;
  assign bus.out_data  = odata_q;
  assign bus.out_keep  = okeep_q;
  assign bus.out_last  = olast_q;
  assign bus.out_user  = ouser_q;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = (state_q == LOCKED);
endmodule

// File: tb/tb_ss_rr_arbiter.sv
// Bench for ss_rr_arbiter: directed packet sources, a per-cycle rule checker
// derived from the handshake/arbitration rules, and literal output logs.
module tb_ss_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int UW = 8;
  localparam int KW = DW / 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ss_rr_arbiter_if #(.NUM_IN(N), .DATA_W(DW), .USER_W(UW)) bus ();
  ss_rr_arbiter #(.NUM_IN(N), .DATA_W(DW), .USER_W(UW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- sources ----------------
  int rem[N], bt[N], pk[N], gap[N], plen[N];
  bit auto_m[N];
  int ordy_mode = 0;
  int pat = 0;

  function automatic logic [DW-1:0] mk_data(int i, int p, int b);
    return 64'hDEAD_0000_0000_0000 | (64'(i) << 16) | (64'(p) << 8) | 64'(b);
  endfunction
  function automatic logic [KW-1:0] mk_keep(int i, int b);
    return KW'(8'hF0 ^ (i * 17 + b));
  endfunction
  function automatic logic [UW-1:0] mk_user(int i, int p);
    return UW'(p * 3 + i + 1);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i]            = (rem[i] > 0) && (gap[i] == 0);
      bus.in_last[i]             = (rem[i] == 1);
      bus.in_data[i*DW +: DW]    = mk_data(i, pk[i], bt[i]);
      bus.in_keep[i*KW +: KW]    = mk_keep(i, bt[i]);
      bus.in_user[i*UW +: UW]    = mk_user(i, pk[i]);
    end
    bus.out_ready = (ordy_mode == 0) ? 1'b1 : (pat % 3 == 0);
  endtask

  task automatic cyc();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = rst ? '0 : (bus.in_valid & bus.in_ready);
    @(posedge clk);
    #1;
    pat++;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        bt[i]++;
        rem[i]--;
        if (rem[i] == 0) begin
          pk[i]++;
          bt[i] = 0;
          if (auto_m[i]) rem[i] = plen[i];
        end
      end
      if (gap[i] > 0) gap[i]--;
    end
    drive();
  endtask

  // ---------------- rule checker ----------------
  logic              p_rst = 1'b1;
  logic              p_busy, p_acc, p_ov, p_ordy, p_lb, p_ol;
  logic [IW-1:0]     p_grant;
  logic [N-1:0]      p_valid, er;
  logic [DW-1:0]     p_bd, p_od;
  logic [KW-1:0]     p_bk, p_ok;
  logic [UW-1:0]     p_bu, p_ou;
  int                m_last = N - 1;
  int                ncyc = 0;
  int                ai;
  int                olog[$], otime[$], glog[$];

  function automatic int rr(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      p_rst  = 1'b1;
      m_last = N - 1;
    end else begin
      if (p_rst) begin
        chk("rst_busy",     bus.busy,      0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready,  0);
        chk("rst_grant",    bus.grant_idx, 0);
      end else begin
        if (p_busy && p_acc && p_lb) m_last = int'(p_grant);
        er = '0;
        if (bus.busy) er[bus.grant_idx] = !bus.out_valid || bus.out_ready;
        chk("in_ready", bus.in_ready, er);
        if (p_acc) begin
          chk("ov_after_accept", bus.out_valid, 1);
          chk("out_data", bus.out_data, p_bd);
          chk("out_keep", bus.out_keep, p_bk);
          chk("out_last", bus.out_last, p_lb);
          chk("out_user", bus.out_user, p_bu);
        end else if (p_ov && !p_ordy) begin
          chk("ov_hold", bus.out_valid, 1);
          chk("hold_data", bus.out_data, p_od);
          chk("hold_keep", bus.out_keep, p_ok);
          chk("hold_last", bus.out_last, p_ol);
          chk("hold_user", bus.out_user, p_ou);
        end else begin
          chk("ov_clear", bus.out_valid, 0);
        end
        if (p_busy) begin
          chk("busy_hold", bus.busy, !(p_acc && p_lb));
          if (bus.busy) chk("grant_hold", bus.grant_idx, p_grant);
        end else begin
          chk("busy_arb", bus.busy, |p_valid);
          if (bus.busy) chk("grant_rr", bus.grant_idx, rr(m_last, p_valid));
        end
      end
      if (bus.busy && (p_rst || !p_busy)) glog.push_back(int'(bus.grant_idx));
      if (bus.out_valid && bus.out_ready) begin
        olog.push_back(int'(bus.out_data[23:16]) * 10000 +
                       int'(bus.out_data[15:8]) * 100 + int'(bus.out_data[7:0]));
        otime.push_back(ncyc);
      end
      p_rst = 1'b0;
    end
    ai = 0;
    for (int i = 0; i < N; i++) if (bus.in_valid[i] && bus.in_ready[i]) ai = i;
    p_acc   = |(bus.in_valid & bus.in_ready);
    p_bd    = bus.in_data[ai*DW +: DW];
    p_bk    = bus.in_keep[ai*KW +: KW];
    p_bu    = bus.in_user[ai*UW +: UW];
    p_lb    = bus.in_last[ai];
    p_busy  = bus.busy;
    p_grant = bus.grant_idx;
    p_valid = bus.in_valid;
    p_ov    = bus.out_valid;
    p_ordy  = bus.out_ready;
    p_od    = bus.out_data;
    p_ok    = bus.out_keep;
    p_ol    = bus.out_last;
    p_ou    = bus.out_user;
    ncyc++;
  end

  // ---------------- scenarios ----------------
  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; bt[i] = 0; pk[i] = 0; gap[i] = 0; plen[i] = 1; auto_m[i] = 0;
    end
    ordy_mode = 0;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    clear_src();
    drive();
    cyc();
    cyc();
    rst = 1'b0;
    olog.delete(); otime.delete(); glog.delete();
  endtask

  task automatic chk_log(input string name, input int exp[]);
    chk({name, "_count"}, olog.size(), exp.size());
    for (int i = 0; i < exp.size() && i < olog.size(); i++)
      chk(name, olog[i], exp[i]);
  endtask

  int idle_bad;

  initial begin
    clear_src();
    drive();
    reset_all();

    // Inputs 0 and 2 with 3-beat packets at once.
    rem[0] = 3; rem[2] = 3; drive();
    for (int c = 0; c < 30 && olog.size() < 6; c++) cyc();
    chk_log("s1_order", '{0, 1, 2, 20000, 20001, 20002});
    chk("s1_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("s1_grant0", glog[0], 0);
      chk("s1_grant1", glog[1], 2);
    end
    if (otime.size() >= 4) begin
      chk("s1_back2back", otime[2] - otime[0], 2);
      chk("s1_bubble",    otime[3] - otime[2], 2);
    end

    // All inputs continuously offering 1-beat packets.
    reset_all();
    for (int i = 0; i < N; i++) begin auto_m[i] = 1; plen[i] = 1; rem[i] = 1; end
    drive();
    for (int c = 0; c < 60 && olog.size() < 8; c++) cyc();
    chk_log("s2_rr", '{0, 10000, 20000, 30000, 100, 10100, 20100, 30100});

    // Input 1 4-beat packet under out_ready 1,0,0 pattern.
    reset_all();
    ordy_mode = 1; pat = 0; rem[1] = 4; drive();
    for (int c = 0; c < 60 && olog.size() < 4; c++) cyc();
    chk_log("s3_stall", '{10000, 10001, 10002, 10003});

    // Input 3 locked, drops valid 5 cycles while input 0 requests.
    reset_all();
    rem[3] = 4; drive();
    cyc(); cyc(); cyc();
    gap[3] = 5; rem[0] = 2; drive();
    for (int c = 0; c < 60 && olog.size() < 6; c++) cyc();
    chk_log("s4_hold", '{30000, 30001, 30002, 30003, 0, 1});
    chk("s4_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("s4_grant0", glog[0], 3);
      chk("s4_grant1", glog[1], 0);
    end

    // Reset in the middle of a 4-beat packet.
    reset_all();
    rem[0] = 4; drive();
    for (int c = 0; c < 20 && olog.size() < 1; c++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clear_src();
    olog.delete(); otime.delete(); glog.delete();
    chk("s5_busy_after_rst", bus.busy, 0);
    chk("s5_ov_after_rst", bus.out_valid, 0);
    pk[0] = 5; rem[0] = 2; drive();
    for (int c = 0; c < 20 && olog.size() < 2; c++) cyc();
    repeat (4) cyc();
    chk_log("s5_new_pkt", '{500, 501});
    chk("s5_grants", glog.size(), 1);
    if (glog.size() >= 1) chk("s5_grant0", glog[0], 0);

    // 20 idle cycles.
    reset_all();
    idle_bad = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (bus.busy || bus.out_valid || (|bus.in_ready)) idle_bad++;
    end
    chk("s6_idle", idle_bad, 0);
    chk("s6_log", olog.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
